// File: rtl/lector_destinos.sv
// lector_destinos: round-robin, rate-limited drain of destination FIFOs
// D0/D1 with tagged delivery, destination checks and per-FIFO counters.
module lector_destinos #(
    parameter int BW = 6,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          enable,
    input  logic [3:0]    rate_div,
    input  logic          clear,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic          D0_error_output,
    input  logic          D1_error_output,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    output logic          D0_rd,
    output logic          D1_rd,
    output logic [BW-1:0] out_data,
    output logic          out_valid,
    output logic          out_dest,
    output logic [CW-1:0] count_D0,
    output logic [CW-1:0] count_D1,
    output logic          dest_error,
    output logic          fifo_error,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic [3:0]    r_gap;
    logic          r_pend;
    logic          r_pend_dest;
    logic          r_valid;
    logic [BW-1:0] r_data;
    logic          r_dest;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;
    logic          r_derr;
    logic          r_ferr;

    logic          w_pop_ok;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_pop;
    logic          w_inc0;
    logic          w_inc1;
    logic          w_bad;
    logic          w_ferr;

    // r_last points at the FIFO served most recently; the other one wins ties
    assign w_pop_ok = (r_state == ARB) & enable;
    assign w_gnt0   = ~D0_empty & (D1_empty | r_last);
    assign w_gnt1   = ~D1_empty & (D0_empty | ~r_last);
    assign D0_rd    = w_pop_ok & w_gnt0;
    assign D1_rd    = w_pop_ok & w_gnt1;
    assign w_pop    = D0_rd | D1_rd;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_gap   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable)
                        r_state <= ARB;
                end
                ARB: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_pop) begin
                        r_last <= D1_rd;
                        if (rate_div != 4'd0) begin
                            r_state <= GAP;
                            r_gap   <= rate_div;
                        end
                    end
                end
                GAP: begin
                    if (r_gap == 4'd1) begin
                        r_gap   <= 4'd0;
                        r_state <= enable ? ARB : IDLE;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gap   <= 4'd0;
                end
            endcase
        end
    end

    // FIFO data is valid the cycle after its pop; register it then
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_pend      <= 1'b0;
            r_pend_dest <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_dest      <= 1'b0;
        end else begin
            r_pend  <= w_pop;
            r_valid <= r_pend;
            if (w_pop)
                r_pend_dest <= D1_rd;
            if (r_pend) begin
                r_data <= r_pend_dest ? D1_data_out : D0_data_out;
                r_dest <= r_pend_dest;
            end
        end
    end

    assign w_inc0 = r_valid & ~r_dest;
    assign w_inc1 = r_valid & r_dest;
    assign w_bad  = r_valid & (r_data[BW-2] != r_dest);
    assign w_ferr = (D0_rd & D0_error_output) | (D1_rd & D1_error_output);

    // clear wins over history but not over an event in the same cycle
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
            r_derr <= 1'b0;
            r_ferr <= 1'b0;
        end else if (clear) begin
            r_cnt0 <= {{(CW-1){1'b0}}, w_inc0};
            r_cnt1 <= {{(CW-1){1'b0}}, w_inc1};
            r_derr <= w_bad;
            r_ferr <= w_ferr;
        end else begin
            r_cnt0 <= r_cnt0 + {{(CW-1){1'b0}}, w_inc0};
            r_cnt1 <= r_cnt1 + {{(CW-1){1'b0}}, w_inc1};
            r_derr <= r_derr | w_bad;
            r_ferr <= r_ferr | w_ferr;
        end
    end

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign out_dest   = r_dest;
    assign count_D0   = r_cnt0;
    assign count_D1   = r_cnt1;
    assign dest_error = r_derr;
    assign fifo_error = r_ferr;
    assign state      = r_state;

endmodule

// File: tb/tb_lector_destinos.sv
// Bench for lector_destinos: queue-based FIFO models, a cycle-level
// reference model compared every cycle, plus directed literal checks.
module tb_lector_destinos;

    localparam int BW = 6;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          enable = 1'b0;
    logic [3:0]    rate_div = 4'd0;
    logic          clear = 1'b0;
    logic          e0 = 1'b1;
    logic          e1 = 1'b1;
    logic          er0 = 1'b0;
    logic          er1 = 1'b0;
    logic [BW-1:0] d0 = '0;
    logic [BW-1:0] d1 = '0;

    logic          rd0, rd1, ov, odst, derr, ferr;
    logic [BW-1:0] odat;
    logic [15:0]   c0, c1;
    logic [1:0]    st;
    logic          rd0s, rd1s, ovs, odsts, derrs, ferrs;
    logic [BW-1:0] odats;
    logic [3:0]    c0s, c1s;
    logic [1:0]    sts;

    always #5 clk = ~clk;

    lector_destinos #(.BW(BW), .CW(16)) u_dut (
        .clk(clk), .reset_L(reset_L), .enable(enable),
        .rate_div(rate_div), .clear(clear),
        .D0_empty(e0), .D1_empty(e1),
        .D0_error_output(er0), .D1_error_output(er1),
        .D0_data_out(d0), .D1_data_out(d1),
        .D0_rd(rd0), .D1_rd(rd1), .out_data(odat),
        .out_valid(ov), .out_dest(odst),
        .count_D0(c0), .count_D1(c1),
        .dest_error(derr), .fifo_error(ferr), .state(st)
    );

    lector_destinos #(.BW(BW), .CW(4)) u_dut4 (
        .clk(clk), .reset_L(reset_L), .enable(enable),
        .rate_div(rate_div), .clear(clear),
        .D0_empty(e0), .D1_empty(e1),
        .D0_error_output(er0), .D1_error_output(er1),
        .D0_data_out(d0), .D1_data_out(d1),
        .D0_rd(rd0s), .D1_rd(rd1s), .out_data(odats),
        .out_valid(ovs), .out_dest(odsts),
        .count_D0(c0s), .count_D1(c1s),
        .dest_error(derrs), .fifo_error(ferrs), .state(sts)
    );

    int unsigned n_err = 0;
    int unsigned n_chk = 0;
    int unsigned n_valid = 0;
    int          cyc = 0;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    bit            s_rd0 = 0;
    bit            s_rd1 = 0;

    typedef struct {
        int            due;
        logic [BW-1:0] w;
        bit            d;
    } del_t;

    bit            m_armed = 0;
    int            m_cool = 0;
    bit            m_last = 1;
    del_t          m_pipe[$];
    logic [BW-1:0] m_odata = '0;
    bit            m_odest = 0;
    int unsigned   m_c0 = 0;
    int unsigned   m_c1 = 0;
    bit            m_derr = 0;
    bit            m_ferr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_armed = 0;
        m_cool  = 0;
        m_last  = 1;
        m_pipe.delete();
        m_odata = '0;
        m_odest = 0;
        m_c0 = 0;
        m_c1 = 0;
        m_derr = 0;
        m_ferr = 0;
    endtask

    // Reference model: eligibility from a cooldown count and an armed flag
    always @(negedge clk) begin
        int   es;
        bit   p0, p1, dv, bad, fe;
        del_t dd, pd;
        cyc++;
        es = 0; p0 = 0; p1 = 0; dv = 0; bad = 0; fe = 0;
        dd = '{0, '0, 0};
        pd = '{0, '0, 0};
        if (!reset_L) begin
            m_reset();
        end else begin
            es = (m_cool > 0) ? 2 : (m_armed ? 1 : 0);
            p0 = (es == 1) && enable && !e0 && (e1 || m_last);
            p1 = (es == 1) && enable && !e1 && (e0 || !m_last);
            if (m_pipe.size() > 0 && m_pipe[0].due == cyc) begin
                dv = 1;
                dd = m_pipe.pop_front();
                m_odata = dd.w;
                m_odest = dd.d;
            end
        end
        chk("state", {30'd0, st}, es);
        chk("D0_rd", {31'd0, rd0}, {31'd0, p0});
        chk("D1_rd", {31'd0, rd1}, {31'd0, p1});
        chk("out_valid", {31'd0, ov}, {31'd0, dv});
        chk("out_data", {26'd0, odat}, {26'd0, m_odata});
        chk("out_dest", {31'd0, odst}, {31'd0, m_odest});
        chk("count_D0", {16'd0, c0}, m_c0 & 32'hFFFF);
        chk("count_D1", {16'd0, c1}, m_c1 & 32'hFFFF);
        chk("dest_error", {31'd0, derr}, {31'd0, m_derr});
        chk("fifo_error", {31'd0, ferr}, {31'd0, m_ferr});
        chk("cw4_rd", {30'd0, rd1s, rd0s}, {30'd0, p1, p0});
        chk("cw4_valid", {31'd0, ovs}, {31'd0, dv});
        chk("cw4_data", {25'd0, odsts, odats}, {25'd0, m_odest, m_odata});
        chk("cw4_state", {30'd0, sts}, es);
        chk("cw4_count_D0", {28'd0, c0s}, m_c0 & 32'hF);
        chk("cw4_count_D1", {28'd0, c1s}, m_c1 & 32'hF);
        chk("cw4_flags", {30'd0, ferrs, derrs}, {30'd0, m_ferr, m_derr});
        if (ov === 1'b1)
            n_valid++;
        s_rd0 = (rd0 === 1'b1);
        s_rd1 = (rd1 === 1'b1);
        if (reset_L) begin
            if (p0 || p1) begin
                pd.due = cyc + 2;
                pd.d   = p1;
                pd.w   = p1 ? q1[0] : q0[0];
                m_pipe.push_back(pd);
                m_last = p1;
                if (rate_div != 0)
                    m_cool = int'(rate_div);
            end else if (es == 1 && !enable) begin
                m_armed = 0;
            end
            if (es == 0 && enable)
                m_armed = 1;
            if (es == 2) begin
                if (m_cool == 1) begin
                    m_cool  = 0;
                    m_armed = enable;
                end else begin
                    m_cool--;
                end
            end
            bad = dv && (dd.w[BW-2] != dd.d);
            fe  = (p0 && er0) || (p1 && er1);
            if (clear) begin
                m_c0   = (dv && !dd.d) ? 1 : 0;
                m_c1   = (dv && dd.d) ? 1 : 0;
                m_derr = bad;
                m_ferr = fe;
            end else begin
                m_c0   += (dv && !dd.d) ? 1 : 0;
                m_c1   += (dv && dd.d) ? 1 : 0;
                m_derr |= bad;
                m_ferr |= fe;
            end
        end
    end

    task automatic upd();
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
    endtask

    // FIFO read side: data appears the cycle after the pop
    always @(posedge clk) begin
        #1;
        if (s_rd0 && q0.size() > 0)
            d0 = q0.pop_front();
        if (s_rd1 && q1.size() > 0)
            d1 = q1.pop_front();
        upd();
    end

    function automatic logic [BW-1:0] mkw(input bit dst);
        logic [BW-1:0] w;
        w = BW'($urandom);
        w[BW-2] = dst;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_rd(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            ok = s_rd0 || s_rd1;
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int unsigned v0;
        logic [BW-1:0] w;
        steps(3);
        chk("rst_state", {30'd0, st}, 32'd0);
        chk("rst_valid", {31'd0, ov}, 32'd0);
        chk("rst_count", {c1, c0}, 32'd0);
        reset_L = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            q0.push_back(mkw(0));
            q1.push_back(mkw(1));
        end
        upd();
        v0 = n_valid;
        enable = 1'b1;
        steps(14);
        chk("s1_count_D0", {16'd0, c0}, 32'd4);
        chk("s1_count_D1", {16'd0, c1}, 32'd4);
        chk("s1_strobes", n_valid - v0, 32'd8);

        enable = 1'b0;
        steps(3);
        pulse_clear();
        for (int i = 0; i < 5; i++)
            q0.push_back(mkw(0));
        upd();
        rate_div = 4'd3;
        enable = 1'b1;
        steps(30);
        chk("s2_count_D0", {16'd0, c0}, 32'd5);
        chk("s2_count_D1", {16'd0, c1}, 32'd0);

        rate_div = 4'd0;
        pulse_clear();
        w = 6'b110001;
        q0.push_back(w);
        upd();
        steps(6);
        chk("s3_dest_error", {31'd0, derr}, 32'd1);
        chk("s3_count_D0", {16'd0, c0}, 32'd1);
        steps(3);
        chk("s3_sticky", {31'd0, derr}, 32'd1);
        pulse_clear();
        chk("s3_cleared", {15'd0, derr, c1, c0}, 32'd0);

        enable = 1'b0;
        steps(3);
        for (int i = 0; i < 3; i++)
            q0.push_back(mkw(0));
        upd();
        enable = 1'b1;
        wait_rd("s4_pop_seen");
        enable = 1'b0;
        steps(5);
        chk("s4_state", {30'd0, st}, 32'd0);
        chk("s4_count_D0", {16'd0, c0}, 32'd1);
        chk("s4_left", q0.size(), 32'd2);

        pulse_clear();
        enable = 1'b1;
        wait_rd("s5_pop_seen");
        reset_L = 1'b0;
        enable = 1'b0;
        v0 = n_valid;
        #1;
        chk("s5_rst_valid", {31'd0, ov}, 32'd0);
        chk("s5_rst_state", {30'd0, st}, 32'd0);
        step();
        reset_L = 1'b1;
        steps(5);
        chk("s5_no_valid", n_valid - v0, 32'd0);
        q0.delete();
        upd();

        pulse_clear();
        for (int i = 0; i < 17; i++)
            q1.push_back(mkw(1));
        upd();
        enable = 1'b1;
        steps(25);
        chk("s6_wrap_cw4", {28'd0, c1s}, 32'd1);
        chk("s6_count_D1", {16'd0, c1}, 32'd17);
        chk("s6_flags", {30'd0, ferrs, derrs}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 7) != 0);
            rate_div = 4'($urandom_range(0, 3));
            clear    = ($urandom_range(0, 49) == 0);
            er0      = ($urandom_range(0, 39) == 0);
            er1      = ($urandom_range(0, 39) == 0);
            reset_L  = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 2) != 0 && q0.size() < 8)
                q0.push_back(mkw($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 2) != 0 && q1.size() < 8)
                q1.push_back(mkw($urandom_range(0, 19) != 0));
            upd();
            step();
        end

        reset_L = 1'b1;
        clear = 1'b0;
        enable = 1'b0;
        steps(10);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
